// File: rtl/cfs_apb_pkg.sv
// Shared types and helpers for the cfs APB requester.
// State encoding, response bundle and address alignment test.
package cfs_apb_pkg;

   localparam int CFS_APB_MAX_ADDR_WIDTH = 32;
   localparam int CFS_APB_MAX_DATA_WIDTH = 32;

   typedef enum logic [1:0] {
      IDLE,
      SETUP,
      ACCESS,
      RESP
   } cfs_apb_state_t;

   typedef struct packed {
      logic [CFS_APB_MAX_DATA_WIDTH-1:0] rdata;
      logic                              err;
      logic                              timeout;
   } cfs_apb_rsp_t;

   function automatic logic cfs_apb_misaligned(
      input logic [CFS_APB_MAX_ADDR_WIDTH-1:0] addr,
      input int unsigned                       nbytes
   );
      logic [CFS_APB_MAX_ADDR_WIDTH-1:0] mask;
      mask = CFS_APB_MAX_ADDR_WIDTH'(nbytes - 1);
      return (addr & mask) != '0;
   endfunction

endpackage

// File: rtl/cfs_apb_timeout_cnt.sv
// Wait-state counter: cleared by load, counts enabled cycles,
// flags the enabled cycle that would reach TIMEOUT_CYCLES (0 = never).
module cfs_apb_timeout_cnt #(
   parameter int TIMEOUT_CYCLES = 16
) (
   input  logic clk_i,
   input  logic rst_i,
   input  logic load_i,
   input  logic en_i,
   output logic expire_o
);

   localparam int CW   = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam int LAST = (TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0;

   logic [CW-1:0] cnt_q;
   logic [CW-1:0] cnt_d;

   assign expire_o = (TIMEOUT_CYCLES != 0) && en_i && (cnt_q == CW'(LAST));

   always_comb begin
      cnt_d = cnt_q;
      if (load_i) begin
         cnt_d = '0;
      end else if (en_i && !expire_o) begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/cfs_apb_master.sv
// APB requester: one command in, SETUP/ACCESS on the bus, one response out.
// Misaligned commands are answered with an error without touching the bus.
module cfs_apb_master
   import cfs_apb_pkg::*;
#(
   parameter int ADDR_WIDTH     = 32,
   parameter int DATA_WIDTH     = 32,
   parameter int TIMEOUT_CYCLES = 16,
   parameter bit ALIGN_CHECK    = 1'b1
) (
   input  logic                  pclk,
   input  logic                  preset,
   input  logic                  req_valid,
   output logic                  req_ready,
   input  logic                  req_write,
   input  logic [ADDR_WIDTH-1:0] req_addr,
   input  logic [DATA_WIDTH-1:0] req_wdata,
   output logic                  rsp_valid,
   input  logic                  rsp_ready,
   output logic [DATA_WIDTH-1:0] rsp_rdata,
   output logic                  rsp_err,
   output logic                  rsp_timeout,
   output logic [ADDR_WIDTH-1:0] paddr,
   output logic                  pwrite,
   output logic                  psel,
   output logic                  penable,
   output logic [DATA_WIDTH-1:0] pwdata,
   input  logic                  pready,
   input  logic [DATA_WIDTH-1:0] prdata,
   input  logic                  pslverr
);

   cfs_apb_state_t        state_q, state_d;
   logic [ADDR_WIDTH-1:0] paddr_q, paddr_d;
   logic                  pwrite_q, pwrite_d;
   logic [DATA_WIDTH-1:0] pwdata_q, pwdata_d;
   cfs_apb_rsp_t          rsp_q, rsp_d;
   logic                  misaligned;
   logic                  to_expire;

   assign misaligned = ALIGN_CHECK &&
      cfs_apb_misaligned(CFS_APB_MAX_ADDR_WIDTH'(req_addr), DATA_WIDTH / 8);

   cfs_apb_timeout_cnt #(
      .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
   ) u_timeout (
      .clk_i   (pclk),
      .rst_i   (preset),
      .load_i  (state_q == SETUP),
      .en_i    ((state_q == ACCESS) && !pready),
      .expire_o(to_expire)
   );

   always_comb begin
      state_d  = state_q;
      paddr_d  = paddr_q;
      pwrite_d = pwrite_q;
      pwdata_d = pwdata_q;
      rsp_d    = rsp_q;
      unique case (state_q)
         IDLE: begin
            if (req_valid) begin
               if (misaligned) begin
                  state_d       = RESP;
                  rsp_d.rdata   = '0;
                  rsp_d.err     = 1'b1;
                  rsp_d.timeout = 1'b0;
               end else begin
                  state_d  = SETUP;
                  paddr_d  = req_addr;
                  pwrite_d = req_write;
                  pwdata_d = req_write ? req_wdata : '0;
               end
            end
         end
         SETUP: state_d = ACCESS;
         ACCESS: begin
            // pready wins over an expiry in the same cycle
            if (pready) begin
               state_d       = RESP;
               rsp_d.err     = pslverr;
               rsp_d.timeout = 1'b0;
               rsp_d.rdata   = (!pwrite_q && !pslverr) ?
                  CFS_APB_MAX_DATA_WIDTH'(prdata) : '0;
            end else if (to_expire) begin
               state_d       = RESP;
               rsp_d.rdata   = '0;
               rsp_d.err     = 1'b1;
               rsp_d.timeout = 1'b1;
            end
         end
         RESP: begin
            if (rsp_ready) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge pclk) begin
      if (preset) begin
         state_q  <= IDLE;
         paddr_q  <= '0;
         pwrite_q <= 1'b0;
         pwdata_q <= '0;
         rsp_q    <= '0;
      end else begin
         state_q  <= state_d;
         paddr_q  <= paddr_d;
         pwrite_q <= pwrite_d;
         pwdata_q <= pwdata_d;
         rsp_q    <= rsp_d;
      end
   end

   assign req_ready   = (state_q == IDLE) && !preset;
   assign psel        = (state_q == SETUP) || (state_q == ACCESS);
   assign penable     = (state_q == ACCESS);
   assign rsp_valid   = (state_q == RESP);
   assign paddr       = paddr_q;
   assign pwrite      = pwrite_q;
   assign pwdata      = pwdata_q;
   assign rsp_rdata   = rsp_q.rdata[DATA_WIDTH-1:0];
   assign rsp_err     = rsp_q.err;
   assign rsp_timeout = rsp_q.timeout;

endmodule
